vme_regbank_pipe: RTL and testbench

Parametrised VME-side register bank: N writable control registers of configurable width behind the VME memory strobe interface (VMERdMem/VMEWrMem with Done pulses). It is the multi-register, address-decoded successor of the single-register pipelined bank. It keeps the registered write-in/read-out pipelining, adds a per-register write pulse, a per-register reset value and optional access-error signalling. It sits between the VME slave core and the application logic.

---
 rtl/vme_regbank_pipe.sv | 154 +++++++++++++++
 tb/tb_vme_regbank_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vme_regbank_pipe.sv
// vme_regbank_pipe: VME-side bank of N_REGS writable control registers.
//
// Write path is two stages (capture, then decode+update), so a write strobe
// in cycle T updates the register and raises VMEWrDone / wr_pulse_o in T+2.
// Read path decodes combinationally and registers data + VMERdDone for T+1.
//
// Ports:
//   Clk, Rst    - rising-edge clock, synchronous active-high reset
//   VMEAddr     - word address shared by both strobes
//   VMEWrData   - write data (low REG_WIDTH bits stored)
//   VMEWrMem    - one-cycle write strobe
//   VMERdMem    - one-cycle read strobe
//   VMERdData   - read data, zero-extended, held between reads
//   VMERdDone   - one-cycle read acknowledge
//   VMEWrDone   - one-cycle write acknowledge
//   regs_o      - flat register contents, reg i at [i*REG_WIDTH +: REG_WIDTH]
//   wr_pulse_o  - per-register pulse in the cycle the register changes
//   VMEAccErr   - unmapped-access pulse (only with VME_REGBANK_ERR_EN)
//
// Build option: define VME_REGBANK_ERR_EN to report unmapped accesses on
// VMEAccErr instead of acknowledging them.
module vme_regbank_pipe #(
    parameter int unsigned N_REGS     = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned REG_WIDTH  = 16,
    parameter logic [N_REGS*REG_WIDTH-1:0] RST_VALS = '0
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [ADDR_WIDTH-1:0]         VMEAddr,
    input  logic [31:0]                   VMEWrData,
    input  logic                          VMEWrMem,
    input  logic                          VMERdMem,
    output logic [31:0]                   VMERdData,
    output logic                          VMERdDone,
    output logic                          VMEWrDone,
    output logic [N_REGS*REG_WIDTH-1:0]   regs_o,
    output logic [N_REGS-1:0]             wr_pulse_o
`ifdef VME_REGBANK_ERR_EN
    ,
    output logic                          VMEAccErr
`endif
);

    localparam int unsigned BANK_W = N_REGS * REG_WIDTH;

`ifdef VME_REGBANK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Captured write request (stage 0)
    typedef struct packed {
        logic                  vld;
        logic [ADDR_WIDTH-1:0] addr;
        logic [REG_WIDTH-1:0]  data;
    } wr_req_t;

    wr_req_t                 wr_s0_q;
    logic [BANK_W-1:0]       regs_q;
    logic [N_REGS-1:0]       wack_q;
    logic [N_REGS-1:0]       wack_c;
    logic                    wr_map_c;
    logic [REG_WIDTH-1:0]    rd_mux_c;
    logic                    rd_map_c;

    // Bits above REG_WIDTH are never stored
    if (REG_WIDTH < 32) begin : g_wr_hi
        logic unused_wr_hi;
        assign unused_wr_hi = ^VMEWrData[31:REG_WIDTH];
    end

    // Stage 0: capture the write request
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_s0_q <= '0;
        end else begin
            wr_s0_q.vld  <= VMEWrMem;
            wr_s0_q.addr <= VMEAddr;
            wr_s0_q.data <= VMEWrData[REG_WIDTH-1:0];
        end
    end

    // Stage 1 decode: one-hot write enable for mapped addresses
    always_comb begin
        wack_c   = '0;
        wr_map_c = 1'b0;
        for (int i = 0; i < int'(N_REGS); i++) begin
            if (wr_s0_q.addr == ADDR_WIDTH'(i)) begin
                wr_map_c  = 1'b1;
                wack_c[i] = wr_s0_q.vld;
            end
        end
    end

    // Stage 1: register update, per-register pulse and write acknowledge
    always_ff @(posedge Clk) begin
        if (Rst) begin
            regs_q    <= RST_VALS;
            wack_q    <= '0;
            VMEWrDone <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                if (wack_c[i]) begin
                    regs_q[i*REG_WIDTH +: REG_WIDTH] <= wr_s0_q.data;
                end
            end
            wack_q    <= wack_c;
            // Unmapped writes are acknowledged only when errors are not reported
            VMEWrDone <= wr_s0_q.vld && (wr_map_c || !ERR_EN);
        end
    end

    // Read mux; unmapped addresses read as zero
    always_comb begin
        rd_mux_c = '0;
        rd_map_c = 1'b0;
        for (int i = 0; i < int'(N_REGS); i++) begin
            if (VMEAddr == ADDR_WIDTH'(i)) begin
                rd_map_c = 1'b1;
                rd_mux_c = regs_q[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // Read data / acknowledge; data holds when no acknowledged read
    always_ff @(posedge Clk) begin
        if (Rst) begin
            VMERdData <= '0;
            VMERdDone <= 1'b0;
        end else begin
            VMERdDone <= VMERdMem && (rd_map_c || !ERR_EN);
            if (VMERdMem && (rd_map_c || !ERR_EN)) begin
                VMERdData <= 32'(rd_mux_c);
            end
        end
    end

`ifdef VME_REGBANK_ERR_EN
    // Error pulse aligned with the Done latency of each path
    always_ff @(posedge Clk) begin
        if (Rst) begin
            VMEAccErr <= 1'b0;
        end else begin
            VMEAccErr <= (VMERdMem && !rd_map_c) || (wr_s0_q.vld && !wr_map_c);
        end
    end
`endif

    assign regs_o     = regs_q;
    assign wr_pulse_o = wack_q;

endmodule

// File: tb/tb_vme_regbank_pipe.sv
// tb_vme_regbank_pipe: directed, table-driven bench for vme_regbank_pipe.
// Each table row drives one cycle of inputs and lists the outputs expected
// in that same cycle; a hand-written tail covers reset abort and read latency.
module tb_vme_regbank_pipe;

    localparam logic [63:0] R0 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] R1 = 64'h0004_ABCD_0002_0001;
    localparam logic [63:0] R2 = 64'h0004_ABCD_0002_1111;
    localparam logic [63:0] R3 = 64'h0004_ABCD_2222_1111;
    localparam logic [63:0] R4 = 64'h0004_3333_2222_1111;
    localparam logic [63:0] R5 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] R6 = 64'h4444_3333_5555_1111;

`ifdef VME_REGBANK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    // Read data left behind by the unmapped read, depending on build
    localparam logic [31:0] E0 = ERR ? 32'h0000_1111 : 32'h0;

    logic        Clk;
    logic        Rst;
    logic [3:0]  VMEAddr;
    logic [31:0] VMEWrData;
    logic        VMEWrMem;
    logic        VMERdMem;
    logic [31:0] VMERdData;
    logic        VMERdDone;
    logic        VMEWrDone;
    logic [63:0] regs_o;
    logic [3:0]  wr_pulse_o;
`ifdef VME_REGBANK_ERR_EN
    logic        VMEAccErr;
`endif

    vme_regbank_pipe #(
        .N_REGS    (4),
        .ADDR_WIDTH(4),
        .REG_WIDTH (16),
        .RST_VALS  (R0)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .VMEAddr   (VMEAddr),
        .VMEWrData (VMEWrData),
        .VMEWrMem  (VMEWrMem),
        .VMERdMem  (VMERdMem),
        .VMERdData (VMERdData),
        .VMERdDone (VMERdDone),
        .VMEWrDone (VMEWrDone),
        .regs_o    (regs_o),
        .wr_pulse_o(wr_pulse_o)
`ifdef VME_REGBANK_ERR_EN
        ,
        .VMEAccErr (VMEAccErr)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        e_rdone;
        logic [31:0] e_rdata;
        logic        e_wdone;
        logic [3:0]  e_pulse;
        logic [63:0] e_regs;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic rst, input logic wr, input logic rd,
                       input logic [3:0] addr, input logic [31:0] wdata,
                       input logic e_rdone, input logic [31:0] e_rdata,
                       input logic e_wdone, input logic [3:0] e_pulse,
                       input logic [63:0] e_regs, input logic e_err);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
        v.e_rdone = e_rdone; v.e_rdata = e_rdata; v.e_wdone = e_wdone;
        v.e_pulse = e_pulse; v.e_regs = e_regs; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        VMEWrMem  = 1'b0;
        VMERdMem  = 1'b0;
        VMEAddr   = '0;
        VMEWrData = '0;
    endtask

    initial begin
        int lat;
        bit seen;

        //   rst wr rd addr wdata            rdone rdata        wdone pulse    regs err
        add(0, 1, 0, 4'd2, 32'h1234_ABCD,   0,    32'h0,       0,    4'b0000, R0, 0);
        add(0, 0, 0, 4'd0, 32'h0,           0,    32'h0,       0,    4'b0000, R0, 0);
        add(0, 0, 0, 4'd0, 32'h0,           0,    32'h0,       1,    4'b0100, R1, 0);
        add(0, 0, 1, 4'd2, 32'h0,           0,    32'h0,       0,    4'b0000, R1, 0);
        add(0, 0, 0, 4'd0, 32'h0,           1,    32'hABCD,    0,    4'b0000, R1, 0);
        add(0, 1, 0, 4'd0, 32'h0000_1111,   0,    32'hABCD,    0,    4'b0000, R1, 0);
        add(0, 1, 0, 4'd1, 32'hFFFF_2222,   0,    32'hABCD,    0,    4'b0000, R1, 0);
        add(0, 1, 0, 4'd2, 32'h0000_3333,   0,    32'hABCD,    1,    4'b0001, R2, 0);
        add(0, 1, 1, 4'd3, 32'h0000_4444,   0,    32'hABCD,    1,    4'b0010, R3, 0);
        add(0, 0, 1, 4'd3, 32'h0,           1,    32'h0004,    1,    4'b0100, R4, 0);
        add(0, 0, 1, 4'd3, 32'h0,           1,    32'h0004,    1,    4'b1000, R5, 0);
        add(0, 0, 1, 4'd0, 32'h0,           1,    32'h4444,    0,    4'b0000, R5, 0);
        add(0, 0, 1, 4'd7, 32'h0,           1,    32'h1111,    0,    4'b0000, R5, 0);
        add(0, 1, 0, 4'd5, 32'hDEAD_BEEF,   !ERR, E0,          0,    4'b0000, R5, ERR);
        add(0, 0, 0, 4'd0, 32'h0,           0,    E0,          0,    4'b0000, R5, 0);
        add(0, 1, 1, 4'd1, 32'h0000_5555,   0,    E0,          !ERR, 4'b0000, R5, ERR);
        add(0, 0, 0, 4'd0, 32'h0,           1,    32'h2222,    0,    4'b0000, R5, 0);
        add(0, 0, 1, 4'd1, 32'h0,           0,    32'h2222,    1,    4'b0010, R6, 0);
        add(1, 1, 0, 4'd0, 32'h0000_7777,   1,    32'h5555,    0,    4'b0000, R6, 0);
        add(0, 0, 0, 4'd0, 32'h0,           0,    32'h0,       0,    4'b0000, R0, 0);
        add(0, 0, 0, 4'd0, 32'h0,           0,    32'h0,       0,    4'b0000, R0, 0);

        // Initial reset
        Rst = 1'b1;
        idle_inputs();
        repeat (2) next_cycle();
        Rst = 1'b0;
        chk("reset_regs",   -1, regs_o, R0);
        chk("reset_rdata",  -1, VMERdData, 32'h0);
        chk("reset_rdone",  -1, VMERdDone, 1'b0);
        chk("reset_wdone",  -1, VMEWrDone, 1'b0);
        chk("reset_pulse",  -1, wr_pulse_o, 4'b0000);

        // Table: check this cycle's outputs, then drive this cycle's inputs
        foreach (vecs[r]) begin
            chk("rd_done",  r, VMERdDone,  vecs[r].e_rdone);
            chk("rd_data",  r, VMERdData,  vecs[r].e_rdata);
            chk("wr_done",  r, VMEWrDone,  vecs[r].e_wdone);
            chk("wr_pulse", r, wr_pulse_o, vecs[r].e_pulse);
            chk("regs",     r, regs_o,     vecs[r].e_regs);
`ifdef VME_REGBANK_ERR_EN
            chk("acc_err",  r, VMEAccErr,  vecs[r].e_err);
`endif
            Rst       = vecs[r].rst;
            VMEWrMem  = vecs[r].wr;
            VMERdMem  = vecs[r].rd;
            VMEAddr   = vecs[r].addr;
            VMEWrData = vecs[r].wdata;
            next_cycle();
        end
        Rst = 1'b0;
        idle_inputs();

        // Reset in T+1 drops a write issued in T
        VMEWrMem  = 1'b1;
        VMEAddr   = 4'd3;
        VMEWrData = 32'h0000_9999;
        next_cycle();
        idle_inputs();
        Rst = 1'b1;
        next_cycle();
        Rst = 1'b0;
        chk("abort_wdone_t2", 100, VMEWrDone, 1'b0);
        chk("abort_pulse_t2", 100, wr_pulse_o, 4'b0000);
        chk("abort_regs_t2",  100, regs_o, R0);
        next_cycle();
        chk("abort_wdone_t3", 101, VMEWrDone, 1'b0);
        chk("abort_pulse_t3", 101, wr_pulse_o, 4'b0000);
        chk("abort_regs_t3",  101, regs_o, R0);

        // Read of register 3 after abort: bounded wait for the acknowledge
        VMERdMem = 1'b1;
        VMEAddr  = 4'd3;
        next_cycle();
        idle_inputs();
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            if (VMERdDone) seen = 1'b1;
            else begin
                next_cycle();
                lat++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rd_timeout: got no VMERdDone expected one within 4 cycles");
        end else begin
            chk("rd_latency", 102, 64'(lat), 64'd1);
            chk("rd_after_abort", 102, VMERdData, 32'h0000_0004);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
